// File: rtl/noc_control_module_lut_burst_conf.sv
// NoC LUT burst configuration controller.
// Collects a 3-flit command (params, target, count) and then issues a burst
// of one-cycle write strobes to the routing/NI LUTs or to a link-enable
// register, stepping the slot index once per strobe.
// Optional feature: define NOC_LUT_CONF_RANGE_CHECK_EN to drop commands whose
// node/sel/data fields are out of range, counting drops in err_cnt.
module noc_control_module_lut_burst_conf #(
  parameter int X         = 3,
  parameter int Y         = 3,
  parameter int LUT_SIZE  = 8,
  parameter int MAX_PORTS = 6,
  parameter int MAX_BURST = 8,
  localparam int NODES    = X * Y,
  localparam int DW       = $clog2(MAX_PORTS + 1),
  localparam int SW       = $clog2(MAX_PORTS),
  localparam int LW       = $clog2(LUT_SIZE),
  localparam int NW       = $clog2(NODES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   flit_data,
  input  logic          flit_valid,
  output logic          flit_ready,
  output logic [DW-1:0] lut_conf_data,
  output logic [SW-1:0] lut_conf_sel,
  output logic [LW-1:0] lut_conf_slot,
  output logic [NW-1:0] config_node,
  output logic          lut_conf_valid,
  output logic          lut_conf_valid_ni,
  output logic          link_en_valid,
  output logic          busy,
  output logic [7:0]    err_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TGT   = 2'd1;
  localparam logic [1:0] CNT   = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;

  // Remaining-strobe counter holds N-1, so the burst cap is MAX_BURST-1.
  localparam logic [7:0] MAXB_M1 = 8'(MAX_BURST - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    data_q, data_d;
  logic [LW-1:0] slot_q, slot_d;
  logic          ni_sel_q, ni_sel_d;
  logic          link_en_q, link_en_d;
  logic [13:0]   node_q, node_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [NW-1:0] cfg_node_q, cfg_node_d;
  logic          lv_q, lv_d;
  logic          lv_ni_q, lv_ni_d;
  logic          le_q, le_d;
  logic          flit_acc;
  logic          drop;
  logic [7:0]    cnt_init;

`ifdef NOC_LUT_CONF_RANGE_CHECK_EN
  localparam logic [13:0] NODES_W = 14'(NODES);
  localparam logic [3:0]  PORTS_W = 4'(MAX_PORTS);
  logic [7:0] err_q, err_d;

  // Out-of-range target, port select or forward value aborts the command.
  assign drop = (node_q >= NODES_W) || (sel_q >= PORTS_W) ||
                (!link_en_q && (data_q > PORTS_W));
  assign err_cnt = err_q;
`else
  logic unused_bits;

  // Without checking the fields are simply truncated to output widths.
  assign drop        = 1'b0;
  assign err_cnt     = 8'd0;
  assign unused_bits = ^{node_q[13:NW], sel_q[3:SW], data_q[3:DW], flit_data[15:8+LW]};
`endif

  assign flit_ready        = (state_q != ISSUE);
  assign busy              = (state_q != IDLE);
  assign flit_acc          = flit_valid && flit_ready;
  assign lut_conf_data     = data_q[DW-1:0];
  assign lut_conf_sel      = sel_q[SW-1:0];
  assign lut_conf_slot     = slot_q;
  assign config_node       = cfg_node_q;
  assign lut_conf_valid    = lv_q;
  assign lut_conf_valid_ni = lv_ni_q;
  assign link_en_valid     = le_q;

  // Link-enable writes are single-slot; otherwise clamp writes-1 to the burst cap.
  assign cnt_init = link_en_q ? 8'd0 :
                    ((flit_data[7:0] > MAXB_M1) ? MAXB_M1 : flit_data[7:0]);

  // Command capture, burst sequencing and next-strobe generation.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    data_d     = data_q;
    slot_d     = slot_q;
    ni_sel_d   = ni_sel_q;
    link_en_d  = link_en_q;
    node_d     = node_q;
    cnt_d      = cnt_q;
    cfg_node_d = '0;
    lv_d       = 1'b0;
    lv_ni_d    = 1'b0;
    le_d       = 1'b0;
`ifdef NOC_LUT_CONF_RANGE_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (flit_acc) begin
          sel_d   = flit_data[3:0];
          data_d  = flit_data[7:4];
          slot_d  = flit_data[8 +: LW];
          state_d = TGT;
        end
      end
      TGT: begin
        if (flit_acc) begin
          ni_sel_d  = flit_data[15];
          link_en_d = flit_data[14];
          node_d    = flit_data[13:0];
          state_d   = CNT;
        end
      end
      CNT: begin
        if (flit_acc) begin
          if (drop) begin
            state_d = IDLE;
`ifdef NOC_LUT_CONF_RANGE_CHECK_EN
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
          end else begin
            state_d    = ISSUE;
            cnt_d      = cnt_init;
            cfg_node_d = node_q[NW-1:0];
            le_d       = link_en_q;
            lv_ni_d    = !link_en_q && ni_sel_q;
            lv_d       = !link_en_q && !ni_sel_q;
          end
        end
      end
      default: begin
        // ISSUE: the strobe for the current slot is already on the outputs.
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d      = cnt_q - 8'd1;
          slot_d     = slot_q + 1'b1;
          cfg_node_d = node_q[NW-1:0];
          le_d       = link_en_q;
          lv_ni_d    = !link_en_q && ni_sel_q;
          lv_d       = !link_en_q && !ni_sel_q;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any command or burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      data_q     <= '0;
      slot_q     <= '0;
      ni_sel_q   <= 1'b0;
      link_en_q  <= 1'b0;
      node_q     <= '0;
      cnt_q      <= '0;
      cfg_node_q <= '0;
      lv_q       <= 1'b0;
      lv_ni_q    <= 1'b0;
      le_q       <= 1'b0;
`ifdef NOC_LUT_CONF_RANGE_CHECK_EN
      err_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      slot_q     <= slot_d;
      ni_sel_q   <= ni_sel_d;
      link_en_q  <= link_en_d;
      node_q     <= node_d;
      cnt_q      <= cnt_d;
      cfg_node_q <= cfg_node_d;
      lv_q       <= lv_d;
      lv_ni_q    <= lv_ni_d;
      le_q       <= le_d;
`ifdef NOC_LUT_CONF_RANGE_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_noc_control_module_lut_burst_conf.sv
// Directed bench for noc_control_module_lut_burst_conf (default parameters).
module tb_noc_control_module_lut_burst_conf;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] flit_data;
  logic        flit_valid;
  logic        flit_ready;
  logic [2:0]  lut_conf_data;
  logic [2:0]  lut_conf_sel;
  logic [2:0]  lut_conf_slot;
  logic [3:0]  config_node;
  logic        lut_conf_valid;
  logic        lut_conf_valid_ni;
  logic        link_en_valid;
  logic        busy;
  logic [7:0]  err_cnt;

  int passed = 0;
  int total  = 0;

  noc_control_module_lut_burst_conf dut (
    .clk               (clk),
    .rst               (rst),
    .flit_data         (flit_data),
    .flit_valid        (flit_valid),
    .flit_ready        (flit_ready),
    .lut_conf_data     (lut_conf_data),
    .lut_conf_sel      (lut_conf_sel),
    .lut_conf_slot     (lut_conf_slot),
    .config_node       (config_node),
    .lut_conf_valid    (lut_conf_valid),
    .lut_conf_valid_ni (lut_conf_valid_ni),
    .link_en_valid     (link_en_valid),
    .busy              (busy),
    .err_cnt           (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [15:0] d);
    flit_data  = d;
    flit_valid = 1'b1;
    tick();
    flit_valid = 1'b0;
  endtask

  task automatic check_no_strobe(input string tag);
    check(tag, {29'd0, lut_conf_valid, lut_conf_valid_ni, link_en_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    flit_data  = 16'h0000;
    flit_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", flit_ready, 1);
    check("rst_busy", busy, 0);
    check_no_strobe("rst_strobes");
    check("rst_slot", lut_conf_slot, 0);
    check("rst_sel", lut_conf_sel, 0);
    check("rst_data", lut_conf_data, 0);
    check("rst_node", config_node, 0);
    check("rst_err", err_cnt, 0);

    // Single LUT write: node 4, sel 2, data 1, slot 3
    send_flit(16'h0312);
    check("t1_busy_tgt", busy, 1);
    send_flit(16'h0004);
    send_flit(16'h0000);
    check("t1_valid", lut_conf_valid, 1);
    check("t1_ni", lut_conf_valid_ni, 0);
    check("t1_link", link_en_valid, 0);
    check("t1_node", config_node, 4);
    check("t1_sel", lut_conf_sel, 2);
    check("t1_data", lut_conf_data, 1);
    check("t1_slot", lut_conf_slot, 3);
    check("t1_ready_issue", flit_ready, 0);
    tick();
    check_no_strobe("t1_after");
    check("t1_ready_after", flit_ready, 1);
    check("t1_busy_after", busy, 0);
    check("t1_node_after", config_node, 0);

    // NI burst of 4 with slot wrap 6,7,0,1
    send_flit(16'h0623);
    send_flit(16'h8001);
    send_flit(16'h0003);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_ni_%0d", i), lut_conf_valid_ni, 1);
      check($sformatf("t2_lv_%0d", i), lut_conf_valid, 0);
      check($sformatf("t2_slot_%0d", i), lut_conf_slot, (6 + i) % 8);
      check($sformatf("t2_ready_%0d", i), flit_ready, 0);
      check($sformatf("t2_node_%0d", i), config_node, 1);
      check($sformatf("t2_sel_%0d", i), lut_conf_sel, 3);
      check($sformatf("t2_data_%0d", i), lut_conf_data, 2);
      tick();
    end
    check_no_strobe("t2_after");
    check("t2_ready_after", flit_ready, 1);

    // Link enable forces a single strobe despite count 6
    send_flit(16'h0100);
    send_flit(16'h4002);
    send_flit(16'h0005);
    check("t3_link", link_en_valid, 1);
    check("t3_lv", lut_conf_valid, 0);
    check("t3_ni", lut_conf_valid_ni, 0);
    check("t3_slot", lut_conf_slot, 1);
    check("t3_node", config_node, 2);
    tick();
    check_no_strobe("t3_after1");
    check("t3_busy", busy, 0);
    tick();
    check_no_strobe("t3_after2");

    // Count 256 clamped to 8; next F0 held during burst, accepted right after
    send_flit(16'h0514);
    send_flit(16'h0003);
    send_flit(16'h00FF);
    flit_data  = 16'h0211;
    flit_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_lv_%0d", i), lut_conf_valid, 1);
      check($sformatf("t4_slot_%0d", i), lut_conf_slot, (5 + i) % 8);
      check($sformatf("t4_ready_%0d", i), flit_ready, 0);
      check($sformatf("t4_node_%0d", i), config_node, 3);
      tick();
    end
    check_no_strobe("t4_after");
    check("t4_ready_after", flit_ready, 1);
    check("t4_sel_held", lut_conf_sel, 4);
    tick();
    flit_valid = 1'b0;
    check("t4b_busy", busy, 1);
    send_flit(16'h0007);
    send_flit(16'h0001);
    check("t4b_lv0", lut_conf_valid, 1);
    check("t4b_slot0", lut_conf_slot, 2);
    check("t4b_sel", lut_conf_sel, 1);
    check("t4b_data", lut_conf_data, 1);
    check("t4b_node", config_node, 7);
    tick();
    check("t4b_lv1", lut_conf_valid, 1);
    check("t4b_slot1", lut_conf_slot, 3);
    tick();
    check_no_strobe("t4b_after");

    // Node 9 on a 3x3 mesh
    send_flit(16'h0000);
    send_flit(16'h0009);
    send_flit(16'h0000);
`ifdef NOC_LUT_CONF_RANGE_CHECK_EN
    check_no_strobe("t5_drop");
    check("t5_err", err_cnt, 1);
    check("t5_busy", busy, 0);
    check("t5_ready", flit_ready, 1);
`else
    check("t5_lv", lut_conf_valid, 1);
    check("t5_node", config_node, 9);
    check("t5_err", err_cnt, 0);
    tick();
    check_no_strobe("t5_after");
`endif

    // Reset during the 2nd strobe of a 4-slot burst
    send_flit(16'h0000);
    send_flit(16'h0002);
    send_flit(16'h0003);
    check("t6_lv0", lut_conf_valid, 1);
    tick();
    check("t6_lv1", lut_conf_valid, 1);
    check("t6_slot1", lut_conf_slot, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_no_strobe("t6_rst");
    check("t6_busy", busy, 0);
    check("t6_err", err_cnt, 0);
    check("t6_ready", flit_ready, 1);
    check("t6_slot", lut_conf_slot, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_no_strobe($sformatf("t6_quiet_%0d", i));
      check($sformatf("t6_busy_%0d", i), busy, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/noc_control_module_lut_burst_conf.md
NOC_CONTROL_MODULE_LUT_BURST_CONF -- requirements
Module: noc_control_module_lut_burst_conf

Interface
REQ-001 Parameter X, default 3, mesh width; Y, default 3, mesh height; NODES = X*Y (localparam).
REQ-002 Parameter LUT_SIZE, default 8, slots per table (power of two, >=2); MAX_PORTS, default 6, ports per router/NI.
REQ-003 Parameter MAX_BURST, default 8, maximum slots written per command (1..LUT_SIZE).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flit_data  input  16  command flit payload; flit_valid  input  1  flit present.
REQ-007 flit_ready  output  1  flit accepted when flit_valid && flit_ready.
REQ-008 lut_conf_data  output  clog2(MAX_PORTS+1)  port to forward / link enable value.
REQ-009 lut_conf_sel  output  clog2(MAX_PORTS)  output port or endpoint selected.
REQ-010 lut_conf_slot  output  clog2(LUT_SIZE)  slot (or link index) written.
REQ-011 config_node  output  clog2(NODES)  target router/NI; 0 when no valid pulse.
REQ-012 lut_conf_valid, lut_conf_valid_ni, link_en_valid  output  1 each  one-cycle write strobes, mutually exclusive.
REQ-013 busy  output  1  command in progress (any state but IDLE); err_cnt  output  8  dropped-command counter.

Function
REQ-014 Command = 3 accepted flits: F0 params (sel=[3:0], data=[7:4], start slot=[15:8]); F1 target (ni_sel=[15], link_en=[14], node=[13:0]); F2 count ([7:0] = writes-1).
REQ-015 FSM states IDLE -> TGT -> CNT -> ISSUE -> IDLE; each of the first three advances only on an accepted flit.
REQ-016 flit_ready SHALL be 1 in IDLE, TGT, CNT and 0 in ISSUE.
REQ-017 Effective count N = min(F2[7:0]+1, MAX_BURST); link_en commands force N=1.
REQ-018 In ISSUE, exactly one strobe per cycle for N consecutive cycles; first strobe the cycle after F2 is accepted.
REQ-019 Strobe select: link_en -> link_en_valid; else ni_sel -> lut_conf_valid_ni; else lut_conf_valid.
REQ-020 lut_conf_slot starts at start slot mod LUT_SIZE, increments by 1 per strobe, wraps LUT_SIZE-1 -> 0.
REQ-021 lut_conf_data, lut_conf_sel, config_node constant over a burst; config_node = node mod 2^clog2(NODES) when checking is off.
REQ-022 After last strobe FSM returns to IDLE; flit_ready is 1 in that same cycle (back-to-back commands, no bubble beyond ISSUE).
REQ-023 Outputs registered; all strobes 0 outside ISSUE.
REQ-024 Flits presented while flit_ready=0 are not consumed and must be held by the source.

Reset
REQ-025 rst SHALL force IDLE, all strobes 0, lut_conf_data/sel/slot 0, config_node 0, busy 0, err_cnt 0, flit_ready 1 next cycle.
REQ-026 rst mid-command or mid-burst SHALL abort it; no further strobes; partial flits discarded.

Configuration
REQ-027 Macro NOC_LUT_CONF_RANGE_CHECK_EN defined: on F2 acceptance, command dropped if node>=NODES, sel>=MAX_PORTS, or data>MAX_PORTS (data check skipped for link_en); drop = no strobes, return to IDLE, err_cnt +1 saturating at 255.
REQ-028 Macro undefined: no checks, fields truncated to output widths, err_cnt tied to 0.

Verification
REQ-029 F0=0x0312, F1=0x0004, F2=0x0000 -> one lut_conf_valid cycle after F2: node 4, sel 2, data 1, slot 3.
REQ-030 F0=0x0623, F1=0x8001, F2=0x0003 (LUT_SIZE 8) -> 4 lut_conf_valid_ni strobes, slots 6,7,0,1; flit_ready 0 for those 4 cycles.
REQ-031 F1=0x4002, F2=0x0005 -> exactly one link_en_valid strobe (link_en forces N=1).
REQ-032 F2=0x00FF with MAX_BURST 8 -> 8 strobes then IDLE; second command back-to-back accepted immediately.
REQ-033 With NOC_LUT_CONF_RANGE_CHECK_EN, node 9 (3x3) -> no strobe, err_cnt 0->1; without macro -> strobe with config_node 9 mod 16 = 9.
REQ-034 rst asserted at 2nd strobe of 4-slot burst -> no further strobes, busy 0, err_cnt 0.
